// File: rtl/nvme_fifo_unpack_if.sv
// nvme_fifo_unpack_if: FIFO read port plus unpacked valid/ready beat stream; master = unpacker, slave = environment
interface nvme_fifo_unpack_if;
  logic [539:0] fifo_q;
  logic fifo_rdempty;
  logic fifo_rdreq;
  logic out_valid;
  logic out_ready;
  logic [511:0] out_data;
  logic [15:0] out_cid;
  logic [7:0] out_opcode;
  logic out_sop;
  logic out_eop;
  logic err;
  logic [1:0] err_code;
  logic [31:0] pkt_count;
  logic [15:0] err_count;
  modport master (
    input fifo_q, fifo_rdempty, out_ready,
    output fifo_rdreq, out_valid, out_data, out_cid, out_opcode, out_sop, out_eop,
    err, err_code, pkt_count, err_count
  );
  modport slave (
    output fifo_q, fifo_rdempty, out_ready,
    input fifo_rdreq, out_valid, out_data, out_cid, out_opcode, out_sop, out_eop,
    err, err_code, pkt_count, err_count
  );
endinterface

// File: rtl/nvme_fifo_unpack.sv
// nvme_fifo_unpack: prefetches 540-bit FIFO entries into a 4-deep skid buffer and unpacks them into framed beats
// Ports: rdclk, aclr (sync active-high reset); bus = nvme_fifo_unpack_if.master
//   fifo_q/fifo_rdempty/fifo_rdreq: FIFO read port, data one cycle after a grant
//   out_*: valid/ready beat stream from the buffer head; err/err_code: framing error pulse and held cause
//   pkt_count/err_count: statistics, present only with NVME_UNPACK_STATS_EN defined, otherwise tied to 0
module nvme_fifo_unpack #(
  parameter int data_width = 540
) (
  input logic rdclk,
  input logic aclr,
  nvme_fifo_unpack_if.master bus
);
  typedef enum logic {EXP_SOP, IN_PKT} state_t;
  state_t r_state, w_next;
  logic [data_width-1:0] w_q;
  logic [537:0] r_mem [4];
  logic [537:0] w_head;
  logic [1:0] r_wp, r_rp;
  logic [2:0] r_count;
  logic r_inflight;
  logic [15:0] r_cid;
  logic r_err;
  logic [1:0] r_err_code, w_code;
  logic w_sop, w_eop, w_mis, w_fwd, w_bad, w_pop, w_done, w_unused;
  assign w_q = bus.fifo_q;
  assign w_sop = w_q[539];
  assign w_eop = w_q[538];
  assign w_mis = w_q[527:512] != r_cid;
  always_comb begin
    w_bad = r_inflight && (r_state == EXP_SOP ? !w_sop : (w_sop || w_mis));
    w_code = r_state == EXP_SOP ? 2'd1 : (w_sop ? 2'd2 : 2'd3);
    w_fwd = r_inflight && (w_sop || (r_state == IN_PKT && !w_mis));
    w_done = w_fwd && w_eop;
    w_next = !r_inflight ? r_state : ((w_fwd && !w_eop) ? IN_PKT : EXP_SOP);
  end
  // inflight reserves a slot so a landing entry always finds room
  assign bus.fifo_rdreq = !bus.fifo_rdempty && !aclr && (r_count + {2'b0, r_inflight}) < 3'd4;
  assign bus.out_valid = r_count != 3'd0 && !aclr;
  assign w_pop = bus.out_valid && bus.out_ready;
  assign w_head = r_mem[r_rp];
  assign bus.out_sop = w_head[537];
  assign bus.out_eop = w_head[536];
  assign bus.out_opcode = w_head[535:528];
  assign bus.out_cid = w_head[527:512];
  assign bus.out_data = w_head[511:0];
  assign bus.err = r_err;
  assign bus.err_code = r_err_code;
  always_ff @(posedge rdclk)
    if (w_fwd) r_mem[r_wp] <= {w_q[539:538], w_q[535:0]};
  always_ff @(posedge rdclk)
    if (aclr) begin
      r_state <= EXP_SOP;
      r_wp <= '0;
      r_rp <= '0;
      r_count <= '0;
      r_inflight <= 1'b0;
      r_cid <= '0;
      r_err <= 1'b0;
      r_err_code <= '0;
    end else begin
      r_state <= w_next;
      r_inflight <= bus.fifo_rdreq && !bus.fifo_rdempty;
      r_count <= r_count + {2'b0, w_fwd} - {2'b0, w_pop};
      if (w_fwd) r_wp <= r_wp + 2'd1;
      if (w_pop) r_rp <= r_rp + 2'd1;
      if (r_inflight && w_sop) r_cid <= w_q[527:512];
      r_err <= w_bad;
      if (w_bad) r_err_code <= w_code;
    end
`ifdef NVME_UNPACK_STATS_EN
  logic [31:0] r_pkt;
  logic [15:0] r_errc;
  assign w_unused = ^w_q[537:536];
  always_ff @(posedge rdclk)
    if (aclr) begin
      r_pkt <= '0;
      r_errc <= '0;
    end else begin
      if (w_done) r_pkt <= r_pkt + 32'd1;
      if (w_bad && r_errc != 16'hFFFF) r_errc <= r_errc + 16'd1;
    end
  assign bus.pkt_count = r_pkt;
  assign bus.err_count = r_errc;
`else
  assign w_unused = ^{w_q[537:536], w_done};
  assign bus.pkt_count = '0;
  assign bus.err_count = '0;
`endif
endmodule

// File: tb/tb_nvme_fifo_unpack.sv
// tb_nvme_fifo_unpack: randomized scoreboard bench for nvme_fifo_unpack with a FIFO model and packet-framing reference
module tb_nvme_fifo_unpack;
  logic rdclk = 1'b0;
  logic aclr = 1'b1;
  always #5 rdclk = ~rdclk;
  nvme_fifo_unpack_if bus();
  nvme_fifo_unpack dut (.rdclk(rdclk), .aclr(aclr), .bus(bus));
  int errors = 0, checks = 0, cyc = 0;
  logic [539:0] fifo[$];
  logic [539:0] exp_q[$];
  int exp_err[$];
  int exp_pkts = 0, exp_errs = 0;
  bit m_in_pkt = 0;
  logic [15:0] m_cid = '0;
  int empty_rate = 0, ready_rate = 100;
  int first_req = -1, first_valid = -1, grants = 0, err_pulses = 0;
  int xfer_cyc[$];
  bit last_req, last_valid;

  function automatic logic [539:0] mk(bit sop, bit eop, logic [15:0] cid, logic [7:0] op);
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    return {sop, eop, 2'($urandom), op, cid, d};
  endfunction

  function automatic int want_p();
`ifdef NVME_UNPACK_STATS_EN
    return exp_pkts;
`else
    return 0;
`endif
  endfunction

  function automatic int want_e();
`ifdef NVME_UNPACK_STATS_EN
    return exp_errs;
`else
    return 0;
`endif
  endfunction

  task automatic set_empty();
    bus.fifo_rdempty = (fifo.size() == 0) || ($urandom_range(0, 99) < empty_rate);
  endtask

  // reference framing: decides each entry's fate purely from the entry sequence
  task automatic push(logic [539:0] e);
    bit sop = e[539], eop = e[538];
    logic [15:0] cid = e[527:512];
    fifo.push_back(e);
    if (!m_in_pkt) begin
      if (sop) begin
        exp_q.push_back(e);
        if (eop) exp_pkts++;
        else begin m_in_pkt = 1; m_cid = cid; end
      end else begin exp_err.push_back(1); exp_errs++; end
    end else if (sop) begin
      exp_err.push_back(2); exp_errs++;
      exp_q.push_back(e);
      if (eop) begin exp_pkts++; m_in_pkt = 0; end
      else m_cid = cid;
    end else if (cid != m_cid) begin
      exp_err.push_back(3); exp_errs++; m_in_pkt = 0;
    end else begin
      exp_q.push_back(e);
      if (eop) begin exp_pkts++; m_in_pkt = 0; end
    end
    set_empty();
  endtask

  task automatic step();
    bit grant;
    int code;
    logic [539:0] e;
    logic [537:0] got, want;
    @(negedge rdclk);
    grant = bus.fifo_rdreq && !bus.fifo_rdempty;
    last_req = bus.fifo_rdreq;
    last_valid = bus.out_valid;
    if (bus.fifo_rdreq && first_req < 0) first_req = cyc;
    if (bus.out_valid && first_valid < 0) first_valid = cyc;
    if (grant) grants++;
    if (bus.err) begin
      err_pulses++;
      checks++;
      if (exp_err.size() == 0) begin
        errors++;
        $display("FAIL err_unexpected: err=1 code=%0d, required err=0", bus.err_code);
      end else begin
        code = exp_err.pop_front();
        if (bus.err_code !== 2'(code)) begin
          errors++;
          $display("FAIL err_code: got %0d, required %0d", bus.err_code, code);
        end
      end
    end
    if (bus.out_valid && bus.out_ready) begin
      xfer_cyc.push_back(cyc);
      checks++;
      got = {bus.out_sop, bus.out_eop, bus.out_opcode, bus.out_cid, bus.out_data};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got cid=%h sop=%0d eop=%0d, required no beat", bus.out_cid, bus.out_sop, bus.out_eop);
      end else begin
        e = exp_q.pop_front();
        want = {e[539:538], e[535:0]};
        if (got !== want) begin
          errors++;
          $display("FAIL beat: got sop=%0d eop=%0d op=%h cid=%h data=%h, required sop=%0d eop=%0d op=%h cid=%h data=%h",
                   got[537], got[536], got[535:528], got[527:512], got[511:0],
                   want[537], want[536], want[535:528], want[527:512], want[511:0]);
        end
      end
    end
    @(posedge rdclk);
    #1;
    cyc++;
    if (grant) bus.fifo_q = fifo.pop_front();
    set_empty();
    bus.out_ready = $urandom_range(0, 99) < ready_rate;
  endtask

  task automatic do_reset(int rr);
    ready_rate = rr;
    bus.out_ready = rr == 100;
    aclr = 1'b1;
    fifo.delete(); exp_q.delete(); exp_err.delete();
    exp_pkts = 0; exp_errs = 0; m_in_pkt = 0;
    step(); step();
    aclr = 1'b0;
    first_req = -1; first_valid = -1; grants = 0; err_pulses = 0;
    xfer_cyc.delete();
  endtask

  task automatic drain(int budget, output bit ok);
    int n = 0;
    while ((exp_q.size() > 0 || fifo.size() > 0) && n < budget) begin step(); n++; end
    repeat (4) step();
    ok = exp_q.size() == 0 && fifo.size() == 0 && exp_err.size() == 0;
  endtask

  task automatic test_reset();
    aclr = 1'b1;
    bus.fifo_rdempty = 1'b0;
    @(negedge rdclk);
    checks++;
    if (bus.fifo_rdreq !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: rdreq=%0d valid=%0d, required 0 0", bus.fifo_rdreq, bus.out_valid);
    end
    @(posedge rdclk); #1;
    bus.fifo_rdempty = 1'b1;
    do_reset(100);
    @(negedge rdclk);
    checks++;
    if (bus.err !== 1'b0 || bus.err_code !== 2'd0 || bus.pkt_count !== 32'd0 || bus.err_count !== 16'd0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: err=%0d code=%0d pkt=%0d errc=%0d valid=%0d, required all 0",
               bus.err, bus.err_code, bus.pkt_count, bus.err_count, bus.out_valid);
    end
    @(posedge rdclk); #1;
  endtask

  task automatic test_single();
    bit ok;
    do_reset(100);
    empty_rate = 0;
    for (int i = 1; i <= 3; i++) push(mk(1, 1, 16'(i), 8'($urandom)));
    drain(100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_drain: leftover beats=%0d errs=%0d, required 0 0", exp_q.size(), exp_err.size()); end
    checks++;
    if (first_valid - first_req != 2) begin
      errors++;
      $display("FAIL single_latency: got %0d cycles, required 2", first_valid - first_req);
    end
    checks++;
    if (xfer_cyc.size() != 3 || xfer_cyc[2] - xfer_cyc[0] != 2) begin
      errors++;
      $display("FAIL single_consecutive: got %0d beats, required 3 on consecutive cycles", xfer_cyc.size());
    end
    checks++;
    if (bus.pkt_count !== 32'(want_p())) begin
      errors++;
      $display("FAIL single_pkt_count: got %0d, required %0d", bus.pkt_count, want_p());
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset(0);
    push(mk(1, 0, 16'h00AB, 8'h02));
    push(mk(0, 0, 16'h00AB, 8'h02));
    push(mk(0, 0, 16'h00AB, 8'h02));
    push(mk(0, 1, 16'h00AB, 8'h02));
    push(mk(1, 1, 16'h00AC, 8'h01));
    push(mk(1, 1, 16'h00AD, 8'h01));
    repeat (10) step();
    checks++;
    if (grants != 4 || last_req !== 1'b0) begin
      errors++;
      $display("FAIL bp_grants: got grants=%0d rdreq=%0d, required 4 0", grants, last_req);
    end
    checks++;
    if (xfer_cyc.size() != 0) begin
      errors++;
      $display("FAIL bp_stall: got %0d beats while stalled, required 0", xfer_cyc.size());
    end
    ready_rate = 100;
    bus.out_ready = 1'b1;
    drain(200, ok);
    checks++;
    if (!ok || xfer_cyc.size() != 6) begin
      errors++;
      $display("FAIL bp_release: got %0d beats, required 6", xfer_cyc.size());
    end
    checks++;
    if (bus.pkt_count !== 32'(want_p())) begin
      errors++;
      $display("FAIL bp_pkt_count: got %0d, required %0d", bus.pkt_count, want_p());
    end
  endtask

  task automatic test_missing_sop();
    bit ok;
    do_reset(100);
    push(mk(0, 1, 16'h0005, 8'h01));
    push(mk(1, 1, 16'h0006, 8'h01));
    drain(100, ok);
    checks++;
    if (!ok || err_pulses != 1 || xfer_cyc.size() != 1) begin
      errors++;
      $display("FAIL missing_sop: got err pulses=%0d beats=%0d, required 1 1", err_pulses, xfer_cyc.size());
    end
    checks++;
    if (bus.err_code !== 2'd1 || bus.err_count !== 16'(want_e())) begin
      errors++;
      $display("FAIL missing_sop_code: got code=%0d errc=%0d, required 1 %0d", bus.err_code, bus.err_count, want_e());
    end
  endtask

  task automatic test_cid_mismatch();
    bit ok;
    do_reset(100);
    push(mk(1, 0, 16'h0010, 8'h02));
    push(mk(0, 1, 16'h0011, 8'h02));
    push(mk(1, 1, 16'h0020, 8'h02));
    drain(100, ok);
    checks++;
    if (!ok || err_pulses != 1 || xfer_cyc.size() != 2 || bus.err_code !== 2'd3) begin
      errors++;
      $display("FAIL cid_mismatch: got pulses=%0d beats=%0d code=%0d, required 1 2 3", err_pulses, xfer_cyc.size(), bus.err_code);
    end
    checks++;
    if (bus.pkt_count !== 32'(want_p())) begin
      errors++;
      $display("FAIL cid_pkt_count: got %0d, required %0d", bus.pkt_count, want_p());
    end
  endtask

  task automatic test_unexpected_sop();
    bit ok;
    do_reset(100);
    push(mk(1, 0, 16'h0030, 8'h02));
    push(mk(1, 0, 16'h0031, 8'h02));
    drain(100, ok);
    checks++;
    if (!ok || xfer_cyc.size() != 2 || bus.err_code !== 2'd2 || bus.pkt_count !== 32'd0) begin
      errors++;
      $display("FAIL unexp_sop: got beats=%0d code=%0d pkt=%0d, required 2 2 0", xfer_cyc.size(), bus.err_code, bus.pkt_count);
    end
    push(mk(0, 1, 16'h0031, 8'h02));
    drain(100, ok);
    checks++;
    if (!ok || bus.pkt_count !== 32'(want_p())) begin
      errors++;
      $display("FAIL unexp_sop_close: got pkt=%0d, required %0d", bus.pkt_count, want_p());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int pre;
    do_reset(0);
    for (int i = 0; i < 4; i++) push(mk(1, 1, 16'h0040 + 16'(i), 8'h03));
    repeat (4) step();
`ifdef NVME_UNPACK_STATS_EN
    pre = 3;
`else
    pre = 0;
`endif
    checks++;
    if (grants != 4 || bus.pkt_count !== 32'(pre)) begin
      errors++;
      $display("FAIL mid_prep: got grants=%0d pkt=%0d, required 4 %0d", grants, bus.pkt_count, pre);
    end
    aclr = 1'b1;
    fifo.delete(); exp_q.delete(); exp_err.delete();
    exp_pkts = 0; exp_errs = 0; m_in_pkt = 0;
    step();
    checks++;
    if (last_valid !== 1'b0 || last_req !== 1'b0) begin
      errors++;
      $display("FAIL mid_in_reset: got valid=%0d rdreq=%0d, required 0 0", last_valid, last_req);
    end
    aclr = 1'b0;
    step();
    checks++;
    if (last_valid !== 1'b0 || bus.pkt_count !== 32'd0) begin
      errors++;
      $display("FAIL mid_after_reset: got valid=%0d pkt=%0d, required 0 0", last_valid, bus.pkt_count);
    end
    ready_rate = 100;
    bus.out_ready = 1'b1;
    xfer_cyc.delete();
    push(mk(1, 1, 16'h0050, 8'h04));
    drain(100, ok);
    checks++;
    if (!ok || xfer_cyc.size() != 1) begin
      errors++;
      $display("FAIL mid_resume: got %0d beats, required 1", xfer_cyc.size());
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n = 0;
    do_reset(100);
    empty_rate = 0;
    while (n < 20) begin
      int len = $urandom_range(1, 4);
      logic [15:0] cid = 16'($urandom);
      for (int j = 0; j < len; j++) push(mk(j == 0, j == len - 1, cid, 8'($urandom)));
      n += len;
    end
    drain(200, ok);
    checks++;
    if (!ok || xfer_cyc.size() != n || xfer_cyc[n-1] - xfer_cyc[0] != n - 1) begin
      errors++;
      $display("FAIL b2b_throughput: got %0d beats over %0d cycles, required %0d over %0d",
               xfer_cyc.size(), xfer_cyc[xfer_cyc.size()-1] - xfer_cyc[0] + 1, n, n);
    end
  endtask

  task automatic test_random();
    bit ok;
    do_reset(70);
    empty_rate = 30;
    for (int i = 0; i < 300; i++)
      push(mk($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 40, 16'h0060 + 16'($urandom_range(0, 2)), 8'($urandom)));
    drain(5000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL random_drain: leftover beats=%0d errs=%0d, required 0 0", exp_q.size(), exp_err.size());
    end
    checks++;
    if (bus.pkt_count !== 32'(want_p()) || bus.err_count !== 16'(want_e())) begin
      errors++;
      $display("FAIL random_stats: got pkt=%0d errc=%0d, required %0d %0d", bus.pkt_count, bus.err_count, want_p(), want_e());
    end
  endtask

  initial begin
    bus.fifo_q = '0;
    bus.fifo_rdempty = 1'b1;
    bus.out_ready = 1'b1;
    test_reset();
    test_single();
    test_backpressure();
    test_missing_sop();
    test_cid_mismatch();
    test_unexpected_sop();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
